// File: rtl/servant_spi_pkg.sv
// Shared types and constants for the servant SPI memory arbiter.
// Imported by the round-robin picker and the arbiter top.
package servant_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY    = 2'b01,
        ST_RECOVER = 2'b10
    } arb_state_t;

    // Read data returned to a requester whose transaction was aborted by the watchdog
    localparam logic [31:0] ABORT_RDT = 32'hFFFF_FFFF;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage : servant_spi_pkg

// File: rtl/servant_rr_pick2.sv
// Combinational two-way round-robin pick.
// On a tie the port that was not served last wins.
module servant_rr_pick2
    import servant_spi_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       pick
);

    // Select the winning port from the request pair and the last-served port
    always_comb begin
        valid = 1'b0;
        pick  = PORT_CPU;
        case (req)
            2'b01: begin
                valid = 1'b1;
                pick  = PORT_CPU;
            end
            2'b10: begin
                valid = 1'b1;
                pick  = PORT_LDR;
            end
            2'b11: begin
                valid = 1'b1;
                pick  = ~last;
            end
            default: begin
                valid = 1'b0;
                pick  = PORT_CPU;
            end
        endcase
    end

endmodule : servant_rr_pick2

// File: rtl/servant_spi_arbiter.sv
// Round-robin Wishbone arbiter sharing the SPI memory master between the CPU bus
// and the boot/debug loader, with a per-transaction watchdog and abort recovery.
module servant_spi_arbiter
    import servant_spi_pkg::*;
#(
    parameter int TIMEOUT = 4096,
    parameter int RECOVER = 16
) (
    input  logic        wb_clk,
    input  logic        wb_rst,

    input  logic [31:0] i_wb_cpu_adr,
    input  logic [31:0] i_wb_cpu_dat,
    input  logic [3:0]  i_wb_cpu_sel,
    input  logic        i_wb_cpu_we,
    input  logic        i_wb_cpu_cyc,
    output logic [31:0] o_wb_cpu_rdt,
    output logic        o_wb_cpu_ack,

    input  logic [31:0] i_wb_ldr_adr,
    input  logic [31:0] i_wb_ldr_dat,
    input  logic [3:0]  i_wb_ldr_sel,
    input  logic        i_wb_ldr_we,
    input  logic        i_wb_ldr_cyc,
    output logic [31:0] o_wb_ldr_rdt,
    output logic        o_wb_ldr_ack,

    output logic [31:0] o_wb_mem_adr,
    output logic [31:0] o_wb_mem_dat,
    output logic [3:0]  o_wb_mem_sel,
    output logic        o_wb_mem_we,
    output logic        o_wb_mem_cyc,
    input  logic [31:0] i_wb_mem_rdt,
    input  logic        i_wb_mem_ack,

    output logic        o_owner,
    output logic        o_busy,
    output logic        o_timeout,
    output logic        o_err_sticky
);

    localparam int MAX_TR = (TIMEOUT > RECOVER) ? TIMEOUT : RECOVER;
    localparam int CW     = (MAX_TR > 2) ? $clog2(MAX_TR) : 1;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TMO  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_REC  = CW'(RECOVER - 1);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic          owner;
    logic          owner_nxt;
    logic          last;
    logic          last_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          err_sticky;

    logic          pick_valid;
    logic          pick;
    logic          owner_cyc;
    logic          abort;
    logic          tmo_force;
    logic          fwd_ack;
    logic [31:0]   fwd_rdt;

    servant_rr_pick2 u_pick (
        .req   ({i_wb_ldr_cyc, i_wb_cpu_cyc}),
        .last  (last),
        .valid (pick_valid),
        .pick  (pick)
    );

    assign owner_cyc = (owner == PORT_LDR) ? i_wb_ldr_cyc : i_wb_cpu_cyc;

    // State, grant bookkeeping, counter and sticky error registers
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state      <= ST_IDLE;
            owner      <= PORT_CPU;
            last       <= PORT_LDR;
            cnt        <= CNT_ZERO;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last       <= last_nxt;
            cnt        <= cnt_nxt;
            err_sticky <= err_sticky | abort;
        end
    end

    // Next-state logic; a slave ack always wins over both abort causes
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = cnt;
        abort     = 1'b0;
        tmo_force = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nxt = ST_BUSY;
                    owner_nxt = pick;
                    last_nxt  = pick;
                    cnt_nxt   = CNT_ZERO;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (i_wb_mem_ack) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = CNT_ZERO;
                end else if (!owner_cyc) begin
                    state_nxt = ST_RECOVER;
                    cnt_nxt   = CNT_ZERO;
                    abort     = 1'b1;
                end else if (cnt == CNT_TMO) begin
                    state_nxt = ST_RECOVER;
                    cnt_nxt   = CNT_ZERO;
                    abort     = 1'b1;
                    tmo_force = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            ST_RECOVER: begin
                if (cnt == CNT_REC) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = CNT_ZERO;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Request mux towards the slave and response demux back to the owner
    always_comb begin
        o_wb_mem_adr = 32'h0000_0000;
        o_wb_mem_dat = 32'h0000_0000;
        o_wb_mem_sel = 4'b0000;
        o_wb_mem_we  = 1'b0;
        o_wb_mem_cyc = 1'b0;
        o_wb_cpu_rdt = 32'h0000_0000;
        o_wb_cpu_ack = 1'b0;
        o_wb_ldr_rdt = 32'h0000_0000;
        o_wb_ldr_ack = 1'b0;
        fwd_ack      = 1'b0;
        fwd_rdt      = 32'h0000_0000;
        if (state == ST_BUSY) begin
            if (owner == PORT_LDR) begin
                o_wb_mem_adr = i_wb_ldr_adr;
                o_wb_mem_dat = i_wb_ldr_dat;
                o_wb_mem_sel = i_wb_ldr_sel;
                o_wb_mem_we  = i_wb_ldr_we;
            end else begin
                o_wb_mem_adr = i_wb_cpu_adr;
                o_wb_mem_dat = i_wb_cpu_dat;
                o_wb_mem_sel = i_wb_cpu_sel;
                o_wb_mem_we  = i_wb_cpu_we;
            end
            // The watchdog cycle drops cyc so the slave sees the transaction end
            o_wb_mem_cyc = owner_cyc & ~tmo_force;
            fwd_ack      = i_wb_mem_ack | tmo_force;
            fwd_rdt      = tmo_force ? ABORT_RDT : i_wb_mem_rdt;
            if (owner == PORT_LDR) begin
                o_wb_ldr_ack = fwd_ack;
                o_wb_ldr_rdt = fwd_rdt;
            end else begin
                o_wb_cpu_ack = fwd_ack;
                o_wb_cpu_rdt = fwd_rdt;
            end
        end else begin
            o_wb_mem_cyc = 1'b0;
        end
    end

    assign o_owner      = owner;
    assign o_busy       = (state == ST_BUSY);
    assign o_timeout    = abort;
    assign o_err_sticky = err_sticky;

endmodule : servant_spi_arbiter

// File: tb/tb_servant_spi_arbiter.sv
// Directed self-checking bench for servant_spi_arbiter (TIMEOUT = 8, RECOVER = 4).
module tb_servant_spi_arbiter;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic [31:0] cpu_adr = 32'h0, cpu_dat = 32'h0;
    logic [3:0]  cpu_sel = 4'h0;
    logic        cpu_we = 1'b0, cpu_cyc = 1'b0;
    logic [31:0] cpu_rdt;
    logic        cpu_ack;
    logic [31:0] ldr_adr = 32'h0, ldr_dat = 32'h0;
    logic [3:0]  ldr_sel = 4'h0;
    logic        ldr_we = 1'b0, ldr_cyc = 1'b0;
    logic [31:0] ldr_rdt;
    logic        ldr_ack;
    logic [31:0] mem_adr, mem_dat;
    logic [3:0]  mem_sel;
    logic        mem_we, mem_cyc;
    logic [31:0] mem_rdt = 32'h0;
    logic        mem_ack = 1'b0;
    logic        owner, busy, tmo, err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 wb_clk = ~wb_clk;

    servant_spi_arbiter #(.TIMEOUT(8), .RECOVER(4)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .i_wb_cpu_adr(cpu_adr), .i_wb_cpu_dat(cpu_dat), .i_wb_cpu_sel(cpu_sel),
        .i_wb_cpu_we(cpu_we), .i_wb_cpu_cyc(cpu_cyc),
        .o_wb_cpu_rdt(cpu_rdt), .o_wb_cpu_ack(cpu_ack),
        .i_wb_ldr_adr(ldr_adr), .i_wb_ldr_dat(ldr_dat), .i_wb_ldr_sel(ldr_sel),
        .i_wb_ldr_we(ldr_we), .i_wb_ldr_cyc(ldr_cyc),
        .o_wb_ldr_rdt(ldr_rdt), .o_wb_ldr_ack(ldr_ack),
        .o_wb_mem_adr(mem_adr), .o_wb_mem_dat(mem_dat), .o_wb_mem_sel(mem_sel),
        .o_wb_mem_we(mem_we), .o_wb_mem_cyc(mem_cyc),
        .i_wb_mem_rdt(mem_rdt), .i_wb_mem_ack(mem_ack),
        .o_owner(owner), .o_busy(busy), .o_timeout(tmo), .o_err_sticky(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 2 time units after the edge
    task automatic tick();
        @(posedge wb_clk);
        #2;
    endtask

    initial begin
        // Reset
        tick(); tick();
        wb_rst = 1'b0;
        check("rst_mem_cyc", 32'(mem_cyc), 32'd0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_ldr_ack", 32'(ldr_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_tmo", 32'(tmo), 32'd0);

        // Port 0 read of 0x100, slave acks 5 cycles after cyc
        cpu_cyc = 1'b1; cpu_adr = 32'h0000_0100; cpu_we = 1'b0; cpu_sel = 4'hF;
        #1 check("rd_grant_latency", 32'(mem_cyc), 32'd0);
        tick();
        check("rd_mem_cyc", 32'(mem_cyc), 32'd1);
        check("rd_mem_adr", mem_adr, 32'h0000_0100);
        check("rd_owner", 32'(owner), 32'd0);
        check("rd_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check("rd_no_early_ack", 32'(cpu_ack), 32'd0);
        mem_ack = 1'b1; mem_rdt = 32'hCAFE_0123;
        #1;
        check("rd_cpu_ack", 32'(cpu_ack), 32'd1);
        check("rd_cpu_rdt", cpu_rdt, 32'hCAFE_0123);
        check("rd_ldr_ack", 32'(ldr_ack), 32'd0);
        check("rd_ldr_rdt", ldr_rdt, 32'h0);
        tick();
        cpu_cyc = 1'b0; mem_ack = 1'b0;
        #1 check("rd_done_busy", 32'(busy), 32'd0);

        // Spurious ack in IDLE
        mem_ack = 1'b1; mem_rdt = 32'h1234_5678;
        #1;
        check("spur_cpu_ack", 32'(cpu_ack), 32'd0);
        check("spur_ldr_ack", 32'(ldr_ack), 32'd0);
        check("spur_cpu_rdt", cpu_rdt, 32'h0);
        check("idle_mem_adr", mem_adr, 32'h0);
        tick();
        mem_ack = 1'b0;
        #1 check("spur_no_grant", 32'(busy), 32'd0);

        // Port 1 write
        ldr_cyc = 1'b1; ldr_adr = 32'h0000_0200; ldr_dat = 32'hDEAD_BEEF;
        ldr_sel = 4'b0011; ldr_we = 1'b1;
        tick();
        check("wr_owner", 32'(owner), 32'd1);
        check("wr_mem_dat", mem_dat, 32'hDEAD_BEEF);
        check("wr_mem_sel", 32'(mem_sel), 32'h3);
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_adr", mem_adr, 32'h0000_0200);
        mem_ack = 1'b1;
        #1;
        check("wr_ldr_ack", 32'(ldr_ack), 32'd1);
        check("wr_cpu_ack", 32'(cpu_ack), 32'd0);
        tick();
        ldr_cyc = 1'b0; mem_ack = 1'b0;

        // Both ports request continuously; slave acks at once
        cpu_cyc = 1'b1; ldr_cyc = 1'b1; ldr_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_mem_cyc", 32'(mem_cyc), 32'd1);
            check("rr_owner", 32'(owner), 32'(i % 2));
            check("rr_mem_adr", mem_adr, (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
            mem_ack = 1'b1;
            #1;
            check("rr_ack", (i % 2 == 0) ? 32'(cpu_ack) : 32'(ldr_ack), 32'd1);
            tick();
            mem_ack = 1'b0;
            #1 check("rr_gap", 32'(mem_cyc), 32'd0);
        end
        cpu_cyc = 1'b0; ldr_cyc = 1'b0;
        tick();

        // Watchdog timeout with TIMEOUT = 8, slave never acks
        cpu_cyc = 1'b1; cpu_adr = 32'h0000_0300;
        tick();
        check("to_grant", 32'(mem_cyc), 32'd1);
        ldr_cyc = 1'b1;
        for (int i = 1; i < 7; i++) tick();
        check("to_early_ack", 32'(cpu_ack), 32'd0);
        check("to_early_tmo", 32'(tmo), 32'd0);
        tick();
        check("to_cpu_ack", 32'(cpu_ack), 32'd1);
        check("to_cpu_rdt", cpu_rdt, 32'hFFFF_FFFF);
        check("to_mem_cyc", 32'(mem_cyc), 32'd0);
        check("to_tmo", 32'(tmo), 32'd1);
        check("to_ldr_ack", 32'(ldr_ack), 32'd0);
        tick();
        cpu_cyc = 1'b0;
        check("to_err", 32'(err), 32'd1);
        check("to_tmo_pulse", 32'(tmo), 32'd0);
        check("rec_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rec_no_grant", 32'(mem_cyc), 32'd0);
        end
        tick();
        check("rec_idle", 32'(mem_cyc), 32'd0);
        tick();
        check("rec_regrant", 32'(mem_cyc), 32'd1);
        check("rec_owner", 32'(owner), 32'd1);
        check("rec_err_held", 32'(err), 32'd1);

        // Reset mid-BUSY with both ports requesting
        cpu_cyc = 1'b1;
        wb_rst = 1'b1;
        tick();
        wb_rst = 1'b0;
        #1;
        check("mrst_mem_cyc", 32'(mem_cyc), 32'd0);
        check("mrst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("mrst_ldr_ack", 32'(ldr_ack), 32'd0);
        check("mrst_err", 32'(err), 32'd0);
        check("mrst_owner", 32'(owner), 32'd0);
        tick();
        check("mrst_grant_owner", 32'(owner), 32'd0);
        check("mrst_grant_cyc", 32'(mem_cyc), 32'd1);
        check("mrst_grant_adr", mem_adr, 32'h0000_0300);

        // Owner drops cyc before ack
        cpu_cyc = 1'b0;
        #1;
        check("pa_tmo", 32'(tmo), 32'd1);
        check("pa_mem_cyc", 32'(mem_cyc), 32'd0);
        tick();
        check("pa_err", 32'(err), 32'd1);
        check("pa_busy", 32'(busy), 32'd0);
        ldr_cyc = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_servant_spi_arbiter
